// File: rtl/vga_rgb_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_rgb_gen_if
// Purpose  : Pattern-select input and registered video outputs of vga_rgb_gen.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_rgb_gen_if;
    logic [1:0] mode;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [7:0] frame;
    logic [7:0] dr;
    logic [7:0] dg;
    logic [7:0] db;

    modport master (
        input  mode,
        output hsync, vsync, visible, hpos, vpos, frame, dr, dg, db
    );

    modport slave (
        output mode,
        input  hsync, vsync, visible, hpos, vpos, frame, dr, dg, db
    );
endinterface
`default_nettype wire

// File: rtl/vga_rgb_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_rgb_gen
// Purpose  : 640x480@60 VGA timing and test-pattern source for the RGB strip.
// Revision : 1.0 - initial release
// ============================================================================
module vga_rgb_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic          clk,
    input  logic          reset,
    vga_rgb_gen_if.master vga
);

    localparam logic [9:0] c_h_vis   = 10'(H_VIS);
    localparam logic [9:0] c_hs_beg  = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_hs_end  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] c_h_last  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_vis   = 10'(V_VIS);
    localparam logic [9:0] c_vs_beg  = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_vs_end  = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] c_v_last  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic [7:0] r_frame_cnt;
    logic [1:0] r_mode;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_visible;
    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    logic [7:0] r_frame;
    logic [7:0] r_dr;
    logic [7:0] r_dg;
    logic [7:0] r_db;

    logic       w_frame_start;
    logic [1:0] w_mode;
    logic       w_h_end;
    logic       w_v_end;
    logic       w_visible;
    logic       w_hsync;
    logic       w_vsync;
    logic [2:0] w_bar;
    logic [7:0] w_checker;
    logic [7:0] w_r;
    logic [7:0] w_g;
    logic [7:0] w_b;

    always_comb begin
        w_frame_start = (r_h == 10'd0) && (r_v == 10'd0);
        // The mode sampled at frame start already applies to pixel (0,0).
        w_mode        = w_frame_start ? vga.mode : r_mode;
        w_h_end       = (r_h == c_h_last);
        w_v_end       = (r_v == c_v_last);
        w_visible     = (r_h < c_h_vis) && (r_v < c_v_vis);
        w_hsync       = !((r_h >= c_hs_beg) && (r_h < c_hs_end));
        w_vsync       = !((r_v >= c_vs_beg) && (r_v < c_vs_end));
        w_bar         = r_h[8:6];
        w_checker     = (r_h[5] ^ r_v[5]) ? 8'hFF : 8'h00;
        w_r           = 8'h00;
        w_g           = 8'h00;
        w_b           = 8'h00;
        if (w_visible) begin
            case (w_mode)
                2'd0: begin
                    w_r = {8{w_bar[2]}};
                    w_g = {8{w_bar[1]}};
                    w_b = {8{w_bar[0]}};
                end
                2'd1: begin
                    w_r = r_h[7:0];
                    w_g = r_v[7:0];
                    w_b = r_frame_cnt;
                end
                2'd2: begin
                    w_r = w_checker;
                    w_g = w_checker;
                    w_b = w_checker;
                end
                default: begin
                    w_r = r_h[7:0] ^ r_v[7:0];
                    w_g = r_h[7:0] ^ r_frame_cnt;
                    w_b = r_v[7:0] + r_frame_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h         <= 10'd0;
            r_v         <= 10'd0;
            r_frame_cnt <= 8'd0;
            r_mode      <= 2'd0;
        end else begin
            r_mode <= w_mode;
            if (w_h_end) begin
                r_h <= 10'd0;
                if (w_v_end) begin
                    r_v         <= 10'd0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_v <= r_v + 10'd1;
                end
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // Single output stage: sync, position and colour all leave on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_visible <= 1'b0;
            r_hpos    <= 10'd0;
            r_vpos    <= 10'd0;
            r_frame   <= 8'd0;
            r_dr      <= 8'd0;
            r_dg      <= 8'd0;
            r_db      <= 8'd0;
        end else begin
            r_hsync   <= w_hsync;
            r_vsync   <= w_vsync;
            r_visible <= w_visible;
            r_hpos    <= r_h;
            r_vpos    <= r_v;
            r_frame   <= r_frame_cnt;
            r_dr      <= w_r;
            r_dg      <= w_g;
            r_db      <= w_b;
        end
    end

    assign vga.hsync   = r_hsync;
    assign vga.vsync   = r_vsync;
    assign vga.visible = r_visible;
    assign vga.hpos    = r_hpos;
    assign vga.vpos    = r_vpos;
    assign vga.frame   = r_frame;
    assign vga.dr      = r_dr;
    assign vga.dg      = r_dg;
    assign vga.db      = r_db;

endmodule
`default_nettype wire

// File: tb/tb_vga_rgb_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_rgb_gen
// Purpose  : Bench for vga_rgb_gen: full-size timing instance plus a shrunken
//            instance so whole frames fit in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_rgb_gen;

    localparam int c_a_hv = 640, c_a_hf = 16, c_a_hs = 96, c_a_hb = 48;
    localparam int c_a_vv = 480, c_a_vf = 10, c_a_vs = 2,  c_a_vb = 33;
    localparam int c_b_hv = 40,  c_b_hf = 2,  c_b_hs = 4,  c_b_hb = 2;
    localparam int c_b_vv = 260, c_b_vf = 2,  c_b_vs = 2,  c_b_vb = 4;
    localparam int c_a_ht = c_a_hv + c_a_hf + c_a_hs + c_a_hb;
    localparam int c_a_vt = c_a_vv + c_a_vf + c_a_vs + c_a_vb;
    localparam int c_b_ht = c_b_hv + c_b_hf + c_b_hs + c_b_hb;
    localparam int c_b_vt = c_b_vv + c_b_vf + c_b_vs + c_b_vb;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vis;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic [7:0] frame;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } px_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0       = 0;

    px_t  q_a[$];
    px_t  q_b[$];
    int   ah, av, af, am;
    int   bh, bv, bf, bm;
    bit   a_ok = 1'b0;
    bit   b_ok = 1'b0;

    vga_rgb_gen_if bus_a ();
    vga_rgb_gen_if bus_b ();

    vga_rgb_gen dut_a (.clk(clk), .reset(rst_a), .vga(bus_a.master));

    vga_rgb_gen #(
        .H_VIS(c_b_hv), .H_FP(c_b_hf), .H_SYNC(c_b_hs), .H_BP(c_b_hb),
        .V_VIS(c_b_vv), .V_FP(c_b_vf), .V_SYNC(c_b_vs), .V_BP(c_b_vb)
    ) dut_b (.clk(clk), .reset(rst_b), .vga(bus_b.master));

    always #5 clk = ~clk;

    function automatic px_t reset_px();
        px_t e;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Reference pixel straight from the behavioural description.
    function automatic px_t model_px(int h, int v, int f, int m, int hv, int hf, int hsw,
                                     int vv, int vf, int vsw);
        px_t e;
        int  bar;
        e       = '0;
        e.hpos  = 10'(h);
        e.vpos  = 10'(v);
        e.frame = 8'(f);
        e.vis   = (h < hv) && (v < vv);
        e.hs    = !((h >= hv + hf) && (h < hv + hf + hsw));
        e.vs    = !((v >= vv + vf) && (v < vv + vf + vsw));
        if (e.vis) begin
            case (m)
                0: begin
                    bar = (h / 64) % 8;
                    e.r = (bar >= 4) ? 8'hFF : 8'h00;
                    e.g = (((bar / 2) % 2) == 1) ? 8'hFF : 8'h00;
                    e.b = ((bar % 2) == 1) ? 8'hFF : 8'h00;
                end
                1: begin
                    e.r = 8'(h % 256);
                    e.g = 8'(v % 256);
                    e.b = 8'(f);
                end
                2: begin
                    e.r = ((((h / 32) + (v / 32)) % 2) == 1) ? 8'hFF : 8'h00;
                    e.g = e.r;
                    e.b = e.r;
                end
                default: begin
                    e.r = 8'((h ^ v) % 256);
                    e.g = 8'((h ^ f) % 256);
                    e.b = 8'((v + f) % 256);
                end
            endcase
        end
        return e;
    endfunction

    function automatic px_t get_out(int sel);
        px_t o;
        if (sel == 0)
            o = {bus_a.hsync, bus_a.vsync, bus_a.visible, bus_a.hpos, bus_a.vpos,
                 bus_a.frame, bus_a.dr, bus_a.dg, bus_a.db};
        else
            o = {bus_b.hsync, bus_b.vsync, bus_b.visible, bus_b.hpos, bus_b.vpos,
                 bus_b.frame, bus_b.dr, bus_b.dg, bus_b.db};
        return o;
    endfunction

    // One clock: push what each DUT should emit for the inputs seen at this
    // edge, then pop and compare once the outputs have settled.
    task automatic cycle();
        px_t ea, eb, ga, gb;
        @(posedge clk);
        if (rst_a) begin
            q_a.push_back(reset_px());
            ah = 0; av = 0; af = 0; am = 0; a_ok = 1'b1;
        end else if (a_ok) begin
            if (ah == 0 && av == 0) am = int'(bus_a.mode);
            q_a.push_back(model_px(ah, av, af, am, c_a_hv, c_a_hf, c_a_hs, c_a_vv, c_a_vf, c_a_vs));
            if (ah == c_a_ht - 1) begin
                ah = 0;
                if (av == c_a_vt - 1) begin av = 0; af = (af + 1) % 256; end
                else av = av + 1;
            end else ah = ah + 1;
        end
        if (rst_b) begin
            q_b.push_back(reset_px());
            bh = 0; bv = 0; bf = 0; bm = 0; b_ok = 1'b1;
        end else if (b_ok) begin
            if (bh == 0 && bv == 0) bm = int'(bus_b.mode);
            q_b.push_back(model_px(bh, bv, bf, bm, c_b_hv, c_b_hf, c_b_hs, c_b_vv, c_b_vf, c_b_vs));
            if (bh == c_b_ht - 1) begin
                bh = 0;
                if (bv == c_b_vt - 1) begin bv = 0; bf = (bf + 1) % 256; end
                else bv = bv + 1;
            end else bh = bh + 1;
        end
        @(negedge clk);
        cyc = cyc + 1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            ga = get_out(0);
            checks++;
            if (ga !== ea) begin
                failures++;
                $display("FAIL scoreboard_a cyc=%0d got=%h exp=%h", cyc, ga, ea);
            end
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            gb = get_out(1);
            checks++;
            if (gb !== eb) begin
                failures++;
                $display("FAIL scoreboard_b cyc=%0d got=%h exp=%h", cyc, gb, eb);
            end
        end
    endtask

    task automatic run_until(int sel, int hp, int vp, int fr, int limit);
        px_t o;
        int  n;
        bit  hit;
        n   = 0;
        o   = get_out(sel);
        hit = (o.hpos == 10'(hp)) && (o.vpos == 10'(vp)) && (fr < 0 || o.frame == 8'(fr));
        while (!hit && n < limit) begin
            cycle();
            n++;
            o   = get_out(sel);
            hit = (o.hpos == 10'(hp)) && (o.vpos == 10'(vp)) && (fr < 0 || o.frame == 8'(fr));
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL run_until dut=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                     sel, o.hpos, o.vpos, o.frame, hp, vp, fr);
        end
    endtask

    task automatic test_reset();
        px_t o;
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.mode = 2'd0; bus_b.mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            o = get_out(0);
            checks++;
            if (o !== reset_px()) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=%h", o, reset_px());
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        cycle();
        t0 = cyc;
        o  = get_out(0);
        checks++;
        if (o.hpos !== 10'd0 || o.vpos !== 10'd0 || o.vis !== 1'b1 || {o.r, o.g, o.b} !== 24'h0) begin
            failures++;
            $display("FAIL first_pixel got=%h exp=hpos0 vpos0 vis1 rgb000000", o);
        end
    endtask

    task automatic test_color_bars();
        px_t o;
        run_until(0, 64, 0, -1, 100);
        o = get_out(0);
        checks++;
        if ({o.r, o.g, o.b} !== 24'h0000FF) begin
            failures++;
            $display("FAIL bar_64 got=%h exp=0000ff", {o.r, o.g, o.b});
        end
        run_until(0, 448, 0, -1, 500);
        o = get_out(0);
        checks++;
        if ({o.r, o.g, o.b} !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL bar_448 got=%h exp=ffffff", {o.r, o.g, o.b});
        end
    endtask

    task automatic test_line_timing();
        px_t o;
        int  fall, rise, low;
        run_until(0, 639, 0, -1, 300);
        o = get_out(0);
        checks++;
        if (o.vis !== 1'b1) begin
            failures++;
            $display("FAIL last_visible got=%b exp=1", o.vis);
        end
        cycle();
        o = get_out(0);
        checks++;
        if (o.hpos !== 10'd640 || o.vis !== 1'b0 || {o.r, o.g, o.b} !== 24'h0) begin
            failures++;
            $display("FAIL blank_640 got=%h exp=hpos640 vis0 rgb0", o);
        end
        fall = -1; rise = -1; low = 0;
        for (int i = 0; i < 300 && rise < 0; i++) begin
            cycle();
            o = get_out(0);
            if (!o.hs) begin
                low++;
                if (fall < 0) fall = int'(o.hpos);
            end else if (fall >= 0) rise = int'(o.hpos);
        end
        checks++;
        if (fall != 656 || rise != 752 || low != 96) begin
            failures++;
            $display("FAIL hsync_pulse got=%0d/%0d/%0d exp=656/752/96", fall, rise, low);
        end
        run_until(0, 0, 1, -1, 200);
        checks++;
        if (cyc - t0 != 800) begin
            failures++;
            $display("FAIL line_period got=%0d exp=800", cyc - t0);
        end
    endtask

    task automatic test_mid_reset(int sel, int hp, int vp, int fr);
        px_t o;
        run_until(sel, hp, vp, fr, 60000);
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        cycle();
        o = get_out(sel);
        checks++;
        if (o !== reset_px()) begin
            failures++;
            $display("FAIL mid_reset dut=%0d got=%h exp=%h", sel, o, reset_px());
        end
        if (sel == 0) rst_a = 1'b0; else rst_b = 1'b0;
        cycle();
        o = get_out(sel);
        checks++;
        if (o.hpos !== 10'd0 || o.vpos !== 10'd0 || o.frame !== 8'd0 || o.hs !== 1'b1 || o.vs !== 1'b1) begin
            failures++;
            $display("FAIL restart dut=%0d got=%h exp=hpos0 vpos0 frame0 hs1 vs1", sel, o);
        end
    endtask

    task automatic test_mode_switch();
        px_t o;
        run_until(1, 0, 100, 0, 6000);
        bus_b.mode = 2'd2;
        run_until(1, 5, 200, 0, 6000);
        o = get_out(1);
        checks++;
        if ({o.r, o.g, o.b} !== 24'h05C800) begin
            failures++;
            $display("FAIL gradient_hold got=%h exp=05c800", {o.r, o.g, o.b});
        end
    endtask

    task automatic test_frame_timing();
        px_t o;
        int  fall, rise, low;
        fall = -1; rise = -1; low = 0;
        for (int i = 0; i < 5000 && rise < 0; i++) begin
            cycle();
            o = get_out(1);
            if (!o.vs) begin
                low++;
                if (fall < 0) fall = int'(o.vpos);
            end else if (fall >= 0) rise = int'(o.vpos);
        end
        checks++;
        if (fall != 262 || rise != 264 || low != 2 * c_b_ht) begin
            failures++;
            $display("FAIL vsync_pulse got=%0d/%0d/%0d exp=262/264/%0d", fall, rise, low, 2 * c_b_ht);
        end
        run_until(1, 0, 0, 1, 6000);
        checks++;
        if (cyc - t0 != c_b_ht * c_b_vt) begin
            failures++;
            $display("FAIL frame_period got=%0d exp=%0d", cyc - t0, c_b_ht * c_b_vt);
        end
    endtask

    task automatic test_checker();
        px_t o;
        run_until(1, 32, 0, 1, 100);
        o = get_out(1);
        checks++;
        if ({o.r, o.g, o.b} !== 24'hFFFFFF) begin
            failures++;
            $display("FAIL checker_32_0 got=%h exp=ffffff", {o.r, o.g, o.b});
        end
        run_until(1, 32, 32, 1, 3000);
        o = get_out(1);
        checks++;
        if ({o.r, o.g, o.b} !== 24'h000000) begin
            failures++;
            $display("FAIL checker_32_32 got=%h exp=000000", {o.r, o.g, o.b});
        end
        bus_b.mode = 2'd3;
    endtask

    task automatic test_xor();
        px_t o;
        run_until(1, 2, 255, 3, 60000);
        o = get_out(1);
        checks++;
        if ({o.r, o.g, o.b} !== 24'hFD0102) begin
            failures++;
            $display("FAIL xor_f3 got=%h exp=fd0102", {o.r, o.g, o.b});
        end
    endtask

    initial begin
        test_reset();
        test_color_bars();
        test_line_timing();
        test_mid_reset(0, 300, 1, -1);
        test_mode_switch();
        test_frame_timing();
        test_checker();
        test_xor();
        test_mid_reset(1, 30, 258, 3);
        repeat (4) cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
